// File: rtl/mc_controller_if.sv
// Control bus between the multicycle controller and the accumulator datapath/memory.
// The controller takes the master modport; the datapath side takes the slave modport.
interface mc_controller_if;
   logic [2:0] opcode;
   logic       acc_zero;
   logic       mem_ready;
   logic       mem_read;
   logic       mem_write;
   logic       iord;
   logic       ir_write;
   logic       mdr_write;
   logic       pc_write;
   logic       pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_func;
   logic       acc_write;
   logic       acc_src;
   logic       instr_done;
   logic       error;
   logic [2:0] state;

   modport master (
      input  opcode, acc_zero, mem_ready,
      output mem_read, mem_write, iord, ir_write, mdr_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_func, acc_write, acc_src, instr_done,
             error, state
   );

   modport slave (
      output opcode, acc_zero, mem_ready,
      input  mem_read, mem_write, iord, ir_write, mdr_write, pc_write, pc_src,
             alu_src_a, alu_src_b, alu_func, acc_write, acc_src, instr_done,
             error, state
   );
endinterface

// File: rtl/mc_controller.sv
// Multicycle control FSM for the 8-bit accumulator datapath: fetch, decode,
// memory access and execute, with a memory-wait timeout that traps in ERROR.
module mc_controller #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input logic              clk,
   input logic              rst,
   mc_controller_if.master  bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEMRD  = 3'd2,
      S_EXEC   = 3'd3,
      S_LOAD   = 3'd4,
      S_MEMWR  = 3'd5,
      S_JUMP   = 3'd6,
      S_ERROR  = 3'd7
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_waiting;
   logic             w_timeout;

   logic       w_mem_read, w_mem_write, w_iord, w_ir_write, w_mdr_write;
   logic       w_pc_write, w_pc_src, w_alu_src_a, w_acc_write, w_acc_src;
   logic       w_instr_done, w_error;
   logic [1:0] w_alu_src_b, w_alu_func;

   assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                      && !bus.mem_ready;
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

   // State register and wait counter; the counter restarts on every state change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_FETCH;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (w_waiting) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Next-state and control outputs; mem_ready-gated strobes are Mealy.
   always_comb begin
      w_next       = r_state;
      w_mem_read   = 1'b0;
      w_mem_write  = 1'b0;
      w_iord       = 1'b0;
      w_ir_write   = 1'b0;
      w_mdr_write  = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = 1'b0;
      w_alu_src_a  = 1'b0;
      w_alu_src_b  = 2'b00;
      w_alu_func   = 2'b00;
      w_acc_write  = 1'b0;
      w_acc_src    = 1'b0;
      w_instr_done = 1'b0;
      w_error      = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_read = 1'b1;
            if (bus.mem_ready) begin
               w_ir_write  = 1'b1;
               w_pc_write  = 1'b1;
               w_alu_src_b = 2'b01;
               w_next      = S_DECODE;
            end else if (w_timeout) begin
               w_next = S_ERROR;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            case (bus.opcode)
               3'b011:  w_next = S_EXEC;
               3'b101:  w_next = S_MEMWR;
               3'b110:  w_next = S_JUMP;
               3'b111: begin
                  if (bus.acc_zero) begin
                     w_next = S_JUMP;
                  end else begin
                     w_instr_done = 1'b1;
                     w_next       = S_FETCH;
                  end
               end
               default: w_next = S_MEMRD;
            endcase
         end
         S_MEMRD: begin
            w_mem_read = 1'b1;
            w_iord     = 1'b1;
            if (bus.mem_ready) begin
               w_mdr_write = 1'b1;
               w_next      = (bus.opcode == 3'b100) ? S_LOAD : S_EXEC;
            end else if (w_timeout) begin
               w_next = S_ERROR;
            end else begin
               w_next = S_MEMRD;
            end
         end
         S_EXEC: begin
            w_alu_src_a  = 1'b1;
            w_alu_func   = bus.opcode[1:0];
            w_acc_write  = 1'b1;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_LOAD: begin
            w_acc_write  = 1'b1;
            w_acc_src    = 1'b1;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_MEMWR: begin
            w_mem_write = 1'b1;
            w_iord      = 1'b1;
            if (bus.mem_ready) begin
               w_instr_done = 1'b1;
               w_next       = S_FETCH;
            end else if (w_timeout) begin
               w_next = S_ERROR;
            end else begin
               w_next = S_MEMWR;
            end
         end
         S_JUMP: begin
            w_pc_write   = 1'b1;
            w_pc_src     = 1'b1;
            w_instr_done = 1'b1;
            w_next       = S_FETCH;
         end
         S_ERROR: begin
            w_error = 1'b1;
            w_next  = S_ERROR;
         end
         default: w_next = S_ERROR;
      endcase
   end

   // Reset blanks every output combinationally, without waiting for a clock.
   assign bus.mem_read   = w_mem_read   & ~rst;
   assign bus.mem_write  = w_mem_write  & ~rst;
   assign bus.iord       = w_iord       & ~rst;
   assign bus.ir_write   = w_ir_write   & ~rst;
   assign bus.mdr_write  = w_mdr_write  & ~rst;
   assign bus.pc_write   = w_pc_write   & ~rst;
   assign bus.pc_src     = w_pc_src     & ~rst;
   assign bus.alu_src_a  = w_alu_src_a  & ~rst;
   assign bus.alu_src_b  = w_alu_src_b  & {2{~rst}};
   assign bus.alu_func   = w_alu_func   & {2{~rst}};
   assign bus.acc_write  = w_acc_write  & ~rst;
   assign bus.acc_src    = w_acc_src    & ~rst;
   assign bus.instr_done = w_instr_done & ~rst;
   assign bus.error      = w_error      & ~rst;
   assign bus.state      = rst ? 3'd0 : r_state;
endmodule
